// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release for the RAM, ramwriter and DAC paths.
// Optional trigger-wait timeout compiled in with RESET_SEQ_TRIG_TIMEOUT_EN.
module reset_sequencer #(
  parameter int DELAY_WIDTH   = 16,
  parameter int TIMEOUT_WIDTH = 28
) (
  input  logic                     clk,
  input  logic                     peripheral_aresetn,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     trigger_mode,
  input  logic                     trigger_in,
  input  logic                     abort_in,
  input  logic [DELAY_WIDTH-1:0]   ramwriter_delay,
  input  logic [DELAY_WIDTH-1:0]   dac_delay,
`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
  input  logic [TIMEOUT_WIDTH-1:0] trig_timeout,
`endif
  output logic                     write_to_ram_aresetn,
  output logic                     write_to_ramwriter_aresetn,
  output logic                     dac_aresetn,
  output logic [7:0]               seq_sts
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARMED      = 3'd1,
    S_REL_RAM    = 3'd2,
    S_REL_WRITER = 3'd3,
    S_RUN        = 3'd4,
    S_ABORT      = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ram_q, ram_d;
  logic                   wr_q, wr_d;
  logic                   dac_q, dac_d;
  logic                   aborted_q, aborted_d;
  logic                   timeout_d;
  logic [7:0]             sts_q, sts_d;
`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                     timeout_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
    timeout_d = timeout_q;
    tcnt_d    = tcnt_q;
`else
    timeout_d = 1'b0;
`endif

    // stop outranks abort_in, which outranks trigger and counter events
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            aborted_d = 1'b0;
            timeout_d = 1'b0;
            state_d   = trigger_mode ? S_ARMED : S_REL_RAM;
          end
        end
        S_ARMED: begin
          if (trigger_in) begin
            state_d = S_REL_RAM;
          end
`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
          else if ((trig_timeout != '0) && (tcnt_q >= trig_timeout - 1'b1)) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
`endif
        end
        S_REL_RAM: begin
          if (abort_in) begin
            state_d   = S_ABORT;
            aborted_d = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = S_REL_WRITER;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_REL_WRITER: begin
          if (abort_in) begin
            state_d   = S_ABORT;
            aborted_d = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          if (abort_in) begin
            state_d   = S_ABORT;
            aborted_d = 1'b1;
          end else if (trigger_mode && !trigger_in) begin
            state_d = S_IDLE;
          end
        end
        S_ABORT: begin
          state_d = S_ABORT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // delays are captured only on the entry edge of a counting state
    if (state_d != state_q) begin
      case (state_d)
        S_REL_RAM:    cnt_d = ramwriter_delay;
        S_REL_WRITER: cnt_d = dac_delay;
        default:      cnt_d = '0;
      endcase
`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
      tcnt_d = '0;
`endif
    end

    // outputs decoded from the next state so they change on the entry edge
    ram_d = 1'b0;
    wr_d  = 1'b0;
    dac_d = 1'b0;
    case (state_d)
      S_REL_RAM: begin
        ram_d = 1'b1;
      end
      S_REL_WRITER: begin
        ram_d = 1'b1;
        wr_d  = 1'b1;
      end
      S_RUN: begin
        ram_d = 1'b1;
        wr_d  = 1'b1;
        dac_d = 1'b1;
      end
      S_ABORT: begin
        ram_d = ram_q;
        wr_d  = wr_q;
      end
      default: begin
        ram_d = 1'b0;
      end
    endcase

    sts_d = {2'b00, timeout_d, aborted_d, (state_d != S_IDLE), state_d};
  end

  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ram_q     <= 1'b0;
      wr_q      <= 1'b0;
      dac_q     <= 1'b0;
      aborted_q <= 1'b0;
      sts_q     <= 8'h00;
`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ram_q     <= ram_d;
      wr_q      <= wr_d;
      dac_q     <= dac_d;
      aborted_q <= aborted_d;
      sts_q     <= sts_d;
`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign write_to_ram_aresetn       = ram_q;
  assign write_to_ramwriter_aresetn = wr_q;
  assign dac_aresetn                = dac_q;
  assign seq_sts                    = sts_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized self-checking bench for reset_sequencer.
// Expected waveforms come from release times computed arithmetically per sequence.
module tb_reset_sequencer;
  localparam int DW = 16;
  localparam int TW = 28;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, trigger_mode, trigger_in, abort_in;
  logic [DW-1:0] ramwriter_delay, dac_delay;
`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
  logic [TW-1:0] trig_timeout;
`endif
  logic          ram, wr, dac;
  logic [7:0]    sts;

  int n_checks = 0;
  int n_errors = 0;

  always #4 clk = ~clk;

  reset_sequencer #(.DELAY_WIDTH(DW), .TIMEOUT_WIDTH(TW)) dut (
    .clk                        (clk),
    .peripheral_aresetn         (rst_n),
    .start                      (start),
    .stop                       (stop),
    .trigger_mode               (trigger_mode),
    .trigger_in                 (trigger_in),
    .abort_in                   (abort_in),
    .ramwriter_delay            (ramwriter_delay),
    .dac_delay                  (dac_delay),
`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
    .trig_timeout               (trig_timeout),
`endif
    .write_to_ram_aresetn       (ram),
    .write_to_ramwriter_aresetn (wr),
    .dac_aresetn                (dac),
    .seq_sts                    (sts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {21'b0, ram, wr, dac, sts};
  endfunction

  function automatic logic [31:0] expv(input logic [2:0] st, input bit r, input bit w,
                                       input bit d, input bit ab, input bit to);
    return {21'b0, r, w, d, 2'b00, to, ab, (st != 3'd0), st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start-to-stop sequence. Edge 1 is the first edge after start is raised.
  // tw: edge at which the ARMED state first sees trigger_in (mode 1 only), ta: abort edge or 0.
  task automatic run_seq(input bit mode, input int rd, input int dd, input int tw, input int ta);
    int t_ram, t_wr, t_run, last;
    logic [2:0] st;
    bit r, w, d, ab;
    t_ram = mode ? tw : 1;
    t_wr  = t_ram + rd + 1;
    t_run = t_wr + dd + 1;
    last  = t_run + 5;
    if (ta + 2 > last) last = ta + 2;
    trigger_mode = mode;
    start = 1'b1;
    for (int e = 1; e <= last; e++) begin
      ramwriter_delay = (e == t_ram) ? DW'(rd) : DW'($urandom);
      dac_delay       = (e == t_wr) ? DW'(dd) : DW'($urandom);
      trigger_in      = mode ? (e >= tw) : 1'($urandom_range(0, 1));
      abort_in        = (ta != 0) && (e == ta);
      tick();
      start = ($urandom_range(0, 3) == 0);
      ab = 1'b0;
      if (ta != 0 && e >= ta) begin
        st = 3'd5; r = (ta - 1 >= t_ram); w = (ta - 1 >= t_wr); d = 1'b0; ab = 1'b1;
      end else if (e < t_ram) begin
        st = 3'd1; r = 1'b0; w = 1'b0; d = 1'b0;
      end else if (e < t_wr) begin
        st = 3'd2; r = 1'b1; w = 1'b0; d = 1'b0;
      end else if (e < t_run) begin
        st = 3'd3; r = 1'b1; w = 1'b1; d = 1'b0;
      end else begin
        st = 3'd4; r = 1'b1; w = 1'b1; d = 1'b1;
      end
      check($sformatf("seq m%0d rd%0d dd%0d ta%0d e%0d", mode, rd, dd, ta, e), obs(),
            expv(st, r, w, d, ab, 1'b0));
    end
    start = 1'b0;
    abort_in = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_to_idle", obs(), expv(3'd0, 1'b0, 1'b0, 1'b0, (ta != 0), 1'b0));
    tick();
    check("idle_holds", obs(), expv(3'd0, 1'b0, 1'b0, 1'b0, (ta != 0), 1'b0));
  endtask

  initial begin
    int rd, dd, tw, ta, t_ram, t_run;
    bit mode;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; trigger_mode = 1'b0;
    trigger_in = 1'b0; abort_in = 1'b0; ramwriter_delay = '0; dac_delay = '0;
`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
    trig_timeout = '0;
`endif
    #3;
    check("reset_state", obs(), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_quiet", obs(), 32'h0);
    end

    // continuous sequence: RAM at +1, ramwriter at +5, DAC at +11
    run_seq(1'b0, 3, 5, 0, 0);
    // trigger wait with the trigger seen 20 cycles after ARMED entry
    run_seq(1'b1, 2, 1, 21, 0);
    // abort in RUN: T_ram=1, T_wr=4, T_run=7
    run_seq(1'b0, 2, 2, 0, 9);
    // zero delays: one cycle per release stage
    run_seq(1'b0, 0, 0, 0, 0);

    // stop and abort together in REL_WRITER
    trigger_mode = 1'b0; ramwriter_delay = '0; dac_delay = 16'd9;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("in_rel_writer", obs(), expv(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    stop = 1'b1; abort_in = 1'b1; tick(); stop = 1'b0; abort_in = 1'b0;
    check("stop_beats_abort", obs(), expv(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // trigger loss in RUN with trigger_mode=1
    trigger_mode = 1'b1; trigger_in = 1'b1; ramwriter_delay = '0; dac_delay = '0;
    start = 1'b1; tick(); start = 1'b0;
    check("armed", obs(), expv(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); tick(); tick();
    check("run_trig", obs(), expv(3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    trigger_in = 1'b0; tick();
    check("trig_loss_idle", obs(), expv(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // asynchronous reset during a REL_RAM count
    trigger_mode = 1'b0; ramwriter_delay = 16'd20;
    start = 1'b1; tick(); start = 1'b0; tick();
    check("mid_count", obs(), expv(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1 check("async_reset", obs(), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("after_async_quiet", obs(), 32'h0);
    end

`ifdef RESET_SEQ_TRIG_TIMEOUT_EN
    trig_timeout = 28'd100; trigger_mode = 1'b1; trigger_in = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int e = 2; e <= 100; e++) tick();
    check("timeout_still_armed", obs(), expv(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    check("timeout_idle", obs(), expv(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    trigger_mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
    check("timeout_cleared", {31'b0, sts[5]}, 32'h0);
    stop = 1'b1; tick(); stop = 1'b0;
    trig_timeout = '0;
`endif

    for (int it = 0; it < 30; it++) begin
      mode  = 1'($urandom_range(0, 1));
      rd    = $urandom_range(0, 6);
      dd    = $urandom_range(0, 6);
      tw    = $urandom_range(2, 8);
      t_ram = mode ? tw : 1;
      t_run = t_ram + rd + dd + 2;
      ta    = ($urandom_range(0, 1) == 1) ? $urandom_range(t_ram + 1, t_run + 4) : 0;
      run_seq(mode, rd, dd, tw, ta);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
